rtc_bus_seq: RTL and testbench
==============================

Name: rtc_bus_seq

Overview:
Parametrised multiplexed address/data bus sequencer for the external real-time-clock chip. It replaces the fixed single-register access engine with these additions:
- programmable strobe timing
- configurable data width
- burst transfers with automatic address increment
- valid/ready handshakes toward the time-keeping and user-edit logic

It sits between the RTC register controller and the chip pins (CS/AD/RD/WR plus the tristate data bus).

Parameters:
DATA_W, 8, width of the address/data bus and register data
T_SETUP, 2, cycles of address/data setup before a strobe (>=1)
T_PULSE, 4, cycles a strobe (wr_n/rd_n) is held low (>=1)
T_HOLD, 2, cycles after strobe release before the phase changes (>=1)
T_RECOV, 3, cycles cs_n is high between beats (>=1)
BURST_MAX, 16, maximum beats per request (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  1  start request, sampled only in IDLE
req_we  in  1  1 = write burst, 0 = read burst
req_addr  in  DATA_W  first register address
req_len  in  $clog2(BURST_MAX)  beats minus one
busy  out  1  high from request acceptance until done
done  out  1  one-cycle pulse when the burst completes
wd_data  in  DATA_W  write data for the current beat
wd_vld  in  1  write data valid
wd_rdy  out  1  one-cycle pulse: wd_data consumed
rd_data  out  DATA_W  read data
rd_vld  out  1  one-cycle pulse, rd_data valid
rd_bcd_err  out  1  read data holds a non-BCD nibble (optional feature)
cs_n  out  1  chip select, active low
ad  out  1  0 = address phase, 1 = data phase
wr_n  out  1  write strobe, active low
rd_n  out  1  read strobe, active low
bus_o  out  DATA_W  value driven on the pad bus
bus_oe  out  1  pad output enable
bus_i  in  DATA_W  pad bus input

Behaviour:
- Reset, asynchronous, active-low:
  - state IDLE; cs_n=1, wr_n=1, rd_n=1, ad=1.
  - bus_oe=0, bus_o=0.
  - busy=0, done=0, wd_rdy=0, rd_vld=0, rd_data=0, rd_bcd_err=0.
  - Reset mid-burst releases all strobes immediately; no done pulse is produced.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_WAIT, D_SETUP, D_STROBE, D_HOLD, RECOV.
- Phase counting: each timed state loads a down-counter with its parameter and exits when the count reaches 1.
- IDLE:
  - req=1 latches we, addr and len, sets busy, and moves to A_SETUP on the next cycle.
  - req outside IDLE is ignored.
- Address phase (A_SETUP, A_STROBE, A_HOLD):
  - cs_n=0, ad=0, bus_oe=1, bus_o=current address.
  - wr_n=0 in A_STROBE only (the address latch strobe is always wr_n).
- D_WAIT (write only):
  - Entered after A_HOLD; waits until wd_vld=1.
  - In the cycle wd_vld=1 it latches wd_data, pulses wd_rdy, and moves to D_SETUP.
  - Reads skip D_WAIT.
- Data phase (D_SETUP, D_STROBE, D_HOLD): ad=1.
  - Write: bus_oe=1, bus_o=latched data, wr_n=0 in D_STROBE.
  - Read: bus_oe=0, rd_n=0 in D_STROBE. bus_i is sampled on the last D_STROBE cycle, and rd_vld pulses with rd_data on the following cycle.
  - There is no read backpressure.
- RECOV: cs_n=1, ad=1, bus_oe=0.
  - If beats remain: increment the address (wraps modulo 2^DATA_W) and return to A_SETUP.
  - Otherwise: pulse done, clear busy, go to IDLE.
- Beat length: 2*(T_SETUP+T_PULSE+T_HOLD)+T_RECOV cycles, plus write stall cycles. This is 19 cycles with the defaults.
- Latency: with req at cycle 0 and no stalls, cs_n falls at cycle 1 and done pulses at cycle 1+N*beat (single beat = cycle 20).
- Strobe safety: wr_n and rd_n are never low together and are never low while cs_n=1. bus_oe is never 1 during a read data phase.
- req_len=BURST_MAX-1 performs BURST_MAX beats; req_len=0 performs one beat.

Optional Feature:
Macro: RTC_BUS_BCD_CHECK_EN.
- Defined: rd_bcd_err is registered alongside rd_data. It is 1 when either nibble of any byte in the sample is greater than 9, and it is valid only while rd_vld=1.
- Undefined: rd_bcd_err is tied to 0 and no check logic is built.

Decomposition:
- Package rtc_bus_pkg:
  - state enum
  - default timing constants (T_SETUP_DEF and related)
  - chip register address constants: seconds, minutes, hours, day, month, year, timer, control
- Sub-module rtc_phase_timer: loadable down-counter with a last-cycle flag, instanced once and shared by all timed states.

Test Plan:
1. Single write, defaults: req_we=1, addr=0x21, len=0, wd_vld held high with data 0x45.
   -> Address 0x21 on bus_o while ad=0. wr_n low 4 cycles in each phase. 0x45 driven during the data phase. wd_rdy one pulse. done at cycle 20.
2. Read burst of 9 from address 0x21 (len=8), bus_i model returns 0x10+addr.
   -> 9 rd_vld pulses with data 0x31..0x39. Addresses 0x21..0x29. rd_n low 4 cycles per beat. done after 1+9*19 cycles.
3. Write stall: wd_vld held low for 10 cycles.
   -> FSM holds in D_WAIT with cs_n=0, ad=0, wr_n=1, bus_oe=1. Completion is delayed exactly 10 cycles.
4. Address wrap: addr=0xFF, len=1, read.
   -> Second beat addresses 0x00.
5. Reset asserted during the D_STROBE of beat 2.
   -> cs_n, wr_n and rd_n go high the same cycle, busy=0, no done pulse. A new req after release completes normally.
6. With RTC_BUS_BCD_CHECK_EN defined, bus_i=0x5A.
   -> rd_bcd_err=1 with rd_vld. With bus_i=0x59, rd_bcd_err=0. Not defined: always 0.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared types, default timing and RTC register map for rtc_bus_seq
package rtc_bus_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int T_SETUP_DEF   = 2;
    localparam int T_PULSE_DEF   = 4;
    localparam int T_HOLD_DEF    = 2;
    localparam int T_RECOV_DEF   = 3;
    localparam int BURST_MAX_DEF = 16;

    localparam logic [7:0] REG_SECONDS = 8'h20;
    localparam logic [7:0] REG_MINUTES = 8'h21;
    localparam logic [7:0] REG_HOURS   = 8'h22;
    localparam logic [7:0] REG_DAY     = 8'h23;
    localparam logic [7:0] REG_MONTH   = 8'h24;
    localparam logic [7:0] REG_YEAR    = 8'h25;
    localparam logic [7:0] REG_TIMER   = 8'h26;
    localparam logic [7:0] REG_CONTROL = 8'h27;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_D_WAIT,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_RECOV
    } rtc_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter flagging the last cycle of a timed phase
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Parks at zero in untimed states so last_o cannot fire spuriously.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/rtc_bus_seq.sv
// rtl/rtc_bus_seq.sv - multiplexed A/D bus burst sequencer for the RTC chip
// Optional BCD check on read data: RTC_BUS_BCD_CHECK_EN.
module rtc_bus_seq
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int T_SETUP   = T_SETUP_DEF,
    parameter int T_PULSE   = T_PULSE_DEF,
    parameter int T_HOLD    = T_HOLD_DEF,
    parameter int T_RECOV   = T_RECOV_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         req_we,
    input  logic [DATA_W-1:0]            req_addr,
    input  logic [$clog2(BURST_MAX)-1:0] req_len,
    output logic                         busy,
    output logic                         done,
    input  logic [DATA_W-1:0]            wd_data,
    input  logic                         wd_vld,
    output logic                         wd_rdy,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_vld,
    output logic                         rd_bcd_err,
    output logic                         cs_n,
    output logic                         ad,
    output logic                         wr_n,
    output logic                         rd_n,
    output logic [DATA_W-1:0]            bus_o,
    output logic                         bus_oe,
    input  logic [DATA_W-1:0]            bus_i
);

    localparam int LEN_W = $clog2(BURST_MAX);
    localparam int CNT_W = $clog2(max_of(max_of(T_SETUP, T_PULSE), max_of(T_HOLD, T_RECOV)) + 1);

    rtc_state_e state_q, state_d;

    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_vld_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_last;

    logic accept, last_recov, next_beat, finish, rd_sample, wd_take;
    logic a_phase, d_phase;

    rtc_phase_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .last_o     (tmr_last)
    );

    assign accept     = (state_q == ST_IDLE) && req;
    assign last_recov = (state_q == ST_RECOV) && tmr_last;
    assign next_beat  = last_recov && (rem_q != '0);
    assign finish     = last_recov && (rem_q == '0);
    assign rd_sample  = (state_q == ST_D_STROBE) && tmr_last && !we_q;
    // Write data accepted at the end of A_HOLD when already valid, so an unstalled beat spends no cycle in D_WAIT.
    assign wd_take    = we_q && wd_vld &&
                        (((state_q == ST_A_HOLD) && tmr_last) || (state_q == ST_D_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d  = ST_A_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP);
                end
            end
            ST_A_SETUP: begin
                if (tmr_last) begin
                    state_d  = ST_A_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_PULSE);
                end
            end
            ST_A_STROBE: begin
                if (tmr_last) begin
                    state_d  = ST_A_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_HOLD);
                end
            end
            ST_A_HOLD: begin
                if (tmr_last) begin
                    if (!we_q || wd_take) begin
                        state_d  = ST_D_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_SETUP);
                    end else begin
                        state_d = ST_D_WAIT;
                    end
                end
            end
            ST_D_WAIT: begin
                if (wd_take) begin
                    state_d  = ST_D_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP);
                end
            end
            ST_D_SETUP: begin
                if (tmr_last) begin
                    state_d  = ST_D_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_PULSE);
                end
            end
            ST_D_STROBE: begin
                if (tmr_last) begin
                    state_d  = ST_D_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_HOLD);
                end
            end
            ST_D_HOLD: begin
                if (tmr_last) begin
                    state_d  = ST_RECOV;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_RECOV);
                end
            end
            ST_RECOV: begin
                if (tmr_last) begin
                    if (rem_q != '0) begin
                        state_d  = ST_A_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_SETUP);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            if (accept) begin
                we_q   <= req_we;
                addr_q <= req_addr;
                rem_q  <= req_len;
                busy_q <= 1'b1;
            end
            if (next_beat) begin
                addr_q <= addr_q + DATA_W'(1);
                rem_q  <= rem_q - LEN_W'(1);
            end
            if (finish) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
            if (wd_take) begin
                data_q <= wd_data;
            end
            if (rd_sample) begin
                rd_vld_q  <= 1'b1;
                rd_data_q <= bus_i;
            end
        end
    end

`ifdef RTC_BUS_BCD_CHECK_EN
    function automatic logic bcd_bad(input logic [DATA_W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DATA_W / 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    logic bcd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_q <= 1'b0;
        end else if (rd_sample) begin
            bcd_q <= bcd_bad(bus_i);
        end
    end

    assign rd_bcd_err = bcd_q;
`else
    assign rd_bcd_err = 1'b0;
`endif

    // Pin decode is pure Moore so an asynchronous reset releases every strobe at once.
    assign a_phase = (state_q == ST_A_SETUP) || (state_q == ST_A_STROBE) ||
                     (state_q == ST_A_HOLD)  || (state_q == ST_D_WAIT);
    assign d_phase = (state_q == ST_D_SETUP) || (state_q == ST_D_STROBE) ||
                     (state_q == ST_D_HOLD);

    always_comb begin
        cs_n   = 1'b1;
        ad     = 1'b1;
        wr_n   = 1'b1;
        rd_n   = 1'b1;
        bus_oe = 1'b0;
        bus_o  = '0;
        if (a_phase) begin
            cs_n   = 1'b0;
            ad     = 1'b0;
            bus_oe = 1'b1;
            bus_o  = addr_q;
            wr_n   = (state_q != ST_A_STROBE);
        end else if (d_phase) begin
            cs_n = 1'b0;
            if (we_q) begin
                bus_oe = 1'b1;
                bus_o  = data_q;
                wr_n   = (state_q != ST_D_STROBE);
            end else begin
                rd_n = (state_q != ST_D_STROBE);
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wd_rdy  = wd_take;
    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_rtc_bus_seq.sv
// tb/tb_rtc_bus_seq.sv - directed table-driven bench for rtc_bus_seq
module tb_rtc_bus_seq;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] wdata;
        int         stall;
        int         exp_done;
        int         exp_beats;
        logic [7:0] exp_addr0;
        logic [7:0] exp_addrn;
        int         exp_wr_lo;
        int         exp_rd_lo;
        int         exp_wdrdy;
        int         exp_rdvld;
        int         exp_ahi;
        int         exp_data_ok;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic       busy, done;
    logic [7:0] wd_data = '0;
    logic       wd_vld = 1'b0;
    logic       wd_rdy;
    logic [7:0] rd_data;
    logic       rd_vld, rd_bcd_err;
    logic       cs_n, ad, wr_n, rd_n;
    logic [7:0] bus_o;
    logic       bus_oe;
    logic [7:0] bus_i;

    logic       force_en = 1'b0;
    logic [7:0] force_val = '0;
    logic [7:0] chip_addr = '0;

    int total = 0;
    int bad   = 0;

    int m_done_cyc, m_ndone, m_beats, m_wr_lo, m_rd_lo, m_wdrdy, m_rdvld;
    int m_rd_bad, m_ahi, m_viol, m_data_ok, m_busy_bad;
    logic [7:0] m_addr0, m_addrn;
    logic       m_bcd_last;

    vec_t vecs[5];

    always #5 clk = ~clk;

    rtc_bus_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .busy       (busy),
        .done       (done),
        .wd_data    (wd_data),
        .wd_vld     (wd_vld),
        .wd_rdy     (wd_rdy),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .rd_bcd_err (rd_bcd_err),
        .cs_n       (cs_n),
        .ad         (ad),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .bus_o      (bus_o),
        .bus_oe     (bus_oe),
        .bus_i      (bus_i)
    );

    // Chip model: latches the address on the address strobe and returns 0x10 + address.
    always @(posedge clk) begin
        if (!cs_n && !ad && !wr_n) chip_addr <= bus_o;
    end
    assign bus_i = force_en ? force_val : (chip_addr + 8'h10);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int k;
        int rd_idx;
        logic stop;
        logic prev_wr;
        logic [7:0] exp_rd;
        m_done_cyc = -1; m_ndone = 0; m_beats = 0; m_wr_lo = 0; m_rd_lo = 0;
        m_wdrdy = 0; m_rdvld = 0; m_rd_bad = 0; m_ahi = 0; m_viol = 0;
        m_data_ok = 0; m_busy_bad = 0; m_addr0 = '0; m_addrn = '0; m_bcd_last = 1'b0;
        @(negedge clk);
        req      = 1'b1;
        req_we   = v.we;
        req_addr = v.addr;
        req_len  = v.len;
        wd_data  = v.wdata;
        wd_vld   = (v.stall == 0);
        k = 0; rd_idx = 0; stop = 1'b0; prev_wr = 1'b1;
        while (!stop) begin
            @(negedge clk);
            k++;
            req    = (k == 5);
            wd_vld = (v.stall == 0) || (k >= 8 + v.stall);
            #1;
            if (!cs_n && !ad && !wr_n && prev_wr) begin
                if (m_beats == 0) m_addr0 = bus_o;
                m_addrn = bus_o;
                m_beats++;
            end
            prev_wr = wr_n;
            if (!wr_n) m_wr_lo++;
            if (!rd_n) m_rd_lo++;
            if (wd_rdy) m_wdrdy++;
            if (rd_vld) begin
                exp_rd = force_en ? force_val : (v.addr + 8'(rd_idx) + 8'h10);
                if (rd_data !== exp_rd) m_rd_bad++;
                rd_idx++;
                m_rdvld++;
                m_bcd_last = rd_bcd_err;
            end
            if (!cs_n && !ad && wr_n && bus_oe) m_ahi++;
            if (!cs_n && ad && !wr_n && bus_o == v.wdata) m_data_ok++;
            if ((!wr_n && !rd_n) || ((!wr_n || !rd_n) && cs_n) || (!v.we && !cs_n && ad && bus_oe))
                m_viol++;
            if (done && m_done_cyc < 0) m_done_cyc = k;
            if (done) m_ndone++;
            if (busy !== (m_done_cyc < 0)) m_busy_bad++;
            if ((m_done_cyc >= 0 && k >= m_done_cyc + 2) || k >= v.exp_done + 20) stop = 1'b1;
        end
        req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int done_seen;
        vec_t vb;

        vecs[0] = '{1'b1, 8'h21, 4'd0,  8'h45, 0,  20,  1,  8'h21, 8'h21, 8,   0,  1,  0, 4,  4};
        vecs[1] = '{1'b0, 8'h21, 4'd8,  8'h00, 0,  172, 9,  8'h21, 8'h29, 36,  36, 0,  9, 36, 0};
        vecs[2] = '{1'b1, 8'h05, 4'd0,  8'hA7, 10, 30,  1,  8'h05, 8'h05, 8,   0,  1,  0, 14, 4};
        vecs[3] = '{1'b0, 8'hFF, 4'd1,  8'h00, 0,  39,  2,  8'hFF, 8'h00, 8,   8,  0,  2, 8,  0};
        vecs[4] = '{1'b1, 8'h10, 4'd15, 8'h3C, 0,  305, 16, 8'h10, 8'h1F, 128, 0,  16, 0, 64, 64};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_pins", {28'd0, cs_n, ad, wr_n, rd_n}, 32'hF);
        chk("rst_bus", {23'd0, bus_oe, bus_o}, 32'h0);
        chk("rst_flags", {27'd0, busy, done, wd_rdy, rd_vld, rd_bcd_err}, 32'h0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i]);
            chk($sformatf("v%0d_done_cycle", i), m_done_cyc, vecs[i].exp_done);
            chk($sformatf("v%0d_done_pulses", i), m_ndone, 1);
            chk($sformatf("v%0d_beats", i), m_beats, vecs[i].exp_beats);
            chk($sformatf("v%0d_addr_first", i), {24'd0, m_addr0}, {24'd0, vecs[i].exp_addr0});
            chk($sformatf("v%0d_addr_last", i), {24'd0, m_addrn}, {24'd0, vecs[i].exp_addrn});
            chk($sformatf("v%0d_wr_low", i), m_wr_lo, vecs[i].exp_wr_lo);
            chk($sformatf("v%0d_rd_low", i), m_rd_lo, vecs[i].exp_rd_lo);
            chk($sformatf("v%0d_wd_rdy", i), m_wdrdy, vecs[i].exp_wdrdy);
            chk($sformatf("v%0d_rd_vld", i), m_rdvld, vecs[i].exp_rdvld);
            chk($sformatf("v%0d_rd_data_bad", i), m_rd_bad, 0);
            chk($sformatf("v%0d_addr_hold_cycles", i), m_ahi, vecs[i].exp_ahi);
            chk($sformatf("v%0d_wdata_driven", i), m_data_ok, vecs[i].exp_data_ok);
            chk($sformatf("v%0d_strobe_safety", i), m_viol, 0);
            chk($sformatf("v%0d_busy", i), m_busy_bad, 0);
        end

        // Reset during the data strobe of beat 2 of a 3-beat write.
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_len = 4'd2;
        wd_data = 8'h66; wd_vld = 1'b1;
        for (k = 1; k <= 31; k++) begin
            @(negedge clk);
            req = 1'b0;
        end
        #1;
        chk("mid_rst_pre_strobe", {30'd0, wr_n, ad}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_pins", {28'd0, cs_n, wr_n, rd_n, busy}, 32'hE);
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("mid_rst_no_done", done_seen, 0);
        run_burst(vecs[0]);
        chk("post_rst_done_cycle", m_done_cyc, 20);
        chk("post_rst_beats", m_beats, 1);

        // BCD check on read data.
        vb = '{1'b0, 8'h40, 4'd0, 8'h00, 0, 20, 1, 8'h40, 8'h40, 4, 4, 0, 1, 4, 0};
        force_en = 1'b1;
        force_val = 8'h5A;
        run_burst(vb);
        chk("bcd_5a_rd_vld", m_rdvld, 1);
        chk("bcd_5a_data", m_rd_bad, 0);
`ifdef RTC_BUS_BCD_CHECK_EN
        chk("bcd_5a_err", {31'd0, m_bcd_last}, 32'd1);
`else
        chk("bcd_5a_err", {31'd0, m_bcd_last}, 32'd0);
`endif
        force_val = 8'h59;
        run_burst(vb);
        chk("bcd_59_err", {31'd0, m_bcd_last}, 32'd0);
        chk("bcd_59_data", m_rd_bad, 0);
        force_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
